// File: rtl/sdram_copy_engine.sv
// Word-by-word SDRAM block copy as an Avalon-MM master:
// read one source word, write it to the destination, repeat.
module sdram_copy_engine #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_address,
    input  logic [ADDR_W-1:0] dst_address,
    input  logic [CNT_W-1:0]  word_count,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] data_buf;

    logic load;
    logic capture;
    logic advance;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (word_count != '0) ? RD_REQ : DONE;
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    capture = 1'b1;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!avm_waitrequest) begin
                    advance = 1'b1;
                    state_d = (remaining != CNT_W'(1)) ? RD_REQ : DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_buf  <= '0;
        end else begin
            if (load) begin
                src_ptr   <= src_address;
                dst_ptr   <= dst_address;
                remaining <= word_count;
            end else if (advance) begin
                // pointers wrap naturally at 2^ADDR_W
                src_ptr   <= src_ptr + ADDR_W'(1);
                dst_ptr   <= dst_ptr + ADDR_W'(1);
                remaining <= remaining - CNT_W'(1);
            end
            if (capture) data_buf <= avm_readdata;
        end
    end

    assign avm_read      = (state == RD_REQ);
    assign avm_write     = (state == WR_REQ);
    assign avm_writedata = data_buf;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    always_comb begin
        avm_address = '0;
        unique case (1'b1)
            (state == RD_REQ): avm_address = src_ptr;
            (state == WR_REQ): avm_address = dst_ptr;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_copy_engine.sv
// Bench for sdram_copy_engine: table of directed transfers, randomized
// transfers against an SDRAM slave model, and reset/start-while-busy cases.
module tb_sdram_copy_engine;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk;
    logic          n_rst;
    logic          start;
    logic [AW-1:0] src_address;
    logic [AW-1:0] dst_address;
    logic [CW-1:0] word_count;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;
    logic          avm_waitrequest;
    logic          busy;
    logic          done;

    sdram_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .start            (start),
        .src_address      (src_address),
        .dst_address      (dst_address),
        .word_count       (word_count),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest  (avm_waitrequest),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_checks = 0;

    // slave configuration, written by the test sequence
    int            stall_cfg = 0;
    int            lat_cfg = 1;
    bit            rnd_cfg = 1'b0;
    bit            use_fixed = 1'b0;
    logic [DW-1:0] fixed_data = '0;
    logic [DW-1:0] salt = '0;
    logic          force_rdv = 1'b0;
    logic [DW-1:0] force_rdata = '0;

    // slave observations, written only by the slave model
    logic [AW-1:0] obs_ra[$];
    logic [AW-1:0] obs_wa[$];
    logic [DW-1:0] obs_wd[$];
    int            done_cnt = 0;
    int            excl_cnt = 0;
    int            stab_cnt = 0;

    function automatic logic [DW-1:0] rd_val(logic [AW-1:0] a);
        if (use_fixed) return fixed_data;
        return ({6'd0, a} * 32'h9E3779B1) ^ salt;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // SDRAM slave: drives waitrequest/readdata mid-cycle
    int            pend = 0;
    logic [AW-1:0] pend_addr = '0;
    bit            in_req = 1'b0;
    int            stall_left = 0;
    logic [AW+DW+1:0] prev_req = '0;

    always @(negedge clk) begin
        avm_readdatavalid = force_rdv;
        avm_readdata      = force_rdv ? force_rdata : '0;
        avm_waitrequest   = 1'b0;
        if (done) done_cnt++;
        if (!n_rst) begin
            pend   = 0;
            in_req = 1'b0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = rd_val(pend_addr);
                end
            end
            if (avm_read && avm_write) excl_cnt++;
            if (avm_read || avm_write) begin
                if (in_req) begin
                    if ({avm_read, avm_write, avm_address, avm_writedata} != prev_req)
                        stab_cnt++;
                end else begin
                    stall_left = rnd_cfg ? int'($urandom_range(0, 2)) : stall_cfg;
                end
                prev_req = {avm_read, avm_write, avm_address, avm_writedata};
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                    in_req = 1'b1;
                end else begin
                    in_req = 1'b0;
                    if (avm_read) begin
                        obs_ra.push_back(avm_address);
                        pend = rnd_cfg ? int'($urandom_range(1, 4)) : lat_cfg;
                        pend_addr = avm_address;
                    end else begin
                        obs_wa.push_back(avm_address);
                        obs_wd.push_back(avm_writedata);
                    end
                end
            end
        end
    end

    task automatic chk_idle(string tag);
        chk({tag, " read"}, avm_read, 0);
        chk({tag, " write"}, avm_write, 0);
        chk({tag, " address"}, avm_address, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
    endtask

    // One transfer; the reference is the plain list of word copies in order.
    task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [CW-1:0] c, input int st, input int lt,
                            input bit rnd, input int inj, input int exp_cyc,
                            input logic [DW-1:0] fx);
        int rd0, wr0, dn0, ex0, sb0, cyc;
        logic [AW-1:0] ea;
        logic [AW-1:0] ew;
        stall_cfg  = st;
        lat_cfg    = lt;
        rnd_cfg    = rnd;
        use_fixed  = (fx != '0);
        fixed_data = fx;
        salt       = $urandom;
        rd0 = obs_ra.size();
        wr0 = obs_wa.size();
        dn0 = done_cnt;
        ex0 = excl_cnt;
        sb0 = stab_cnt;
        @(negedge clk);
        src_address = s;
        dst_address = d;
        word_count  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 2000) begin
            if (inj != 0 && cyc == inj) begin
                start = 1'b1;
                src_address = s ^ 26'h0155;
                dst_address = d ^ 26'h02AA;
                word_count  = 16'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done reached", done, 1);
        if (exp_cyc >= 0) chk("done latency", cyc, exp_cyc);
        chk("busy in done", busy, 1);
        @(negedge clk);
        chk_idle("after done");
        chk("done pulses", done_cnt - dn0, 1);
        chk("read count", obs_ra.size() - rd0, c);
        chk("write count", obs_wa.size() - wr0, c);
        for (int i = 0; i < int'(c); i++) begin
            ea = s + AW'(i);
            ew = d + AW'(i);
            if (rd0 + i < obs_ra.size())
                chk($sformatf("read addr %0d", i), obs_ra[rd0+i], ea);
            if (wr0 + i < obs_wa.size()) begin
                chk($sformatf("write addr %0d", i), obs_wa[wr0+i], ew);
                chk($sformatf("write data %0d", i), obs_wd[wr0+i], rd_val(ea));
            end
        end
        chk("read/write exclusive", excl_cnt - ex0, 0);
        chk("stable under stall", stab_cnt - sb0, 0);
    endtask

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [CW-1:0] cnt;
        int            stall;
        int            lat;
        int            inj;
        int            exp_cyc;
        logic [DW-1:0] fixed;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // cycles from start edge to done: N*(2*stall + 2 + latency) + 1
        vecs[0] = '{26'h0000100, 26'h0200000, 16'd1, 0, 1, 0, 4, 32'hDEADBEEF};
        vecs[1] = '{26'h0001000, 26'h0002000, 16'd4, 2, 3, 0, 37, 32'h0};
        vecs[2] = '{26'h0000040, 26'h0000080, 16'd0, 0, 1, 0, 1, 32'h0};
        vecs[3] = '{26'h3FFFFFE, 26'h3FFFFFF, 16'd3, 0, 1, 0, 10, 32'h0};
        vecs[4] = '{26'h0000500, 26'h0000600, 16'd2, 0, 3, 2, 11, 32'h0};
        vecs[5] = '{26'h0123456, 26'h0123458, 16'd3, 1, 2, 0, 19, 32'h0};

        start = 1'b0;
        src_address = '0;
        dst_address = '0;
        word_count = '0;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset writedata", avm_writedata, 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk_idle("post reset");

        for (int k = 0; k < 6; k++)
            run_xfer(vecs[k].src, vecs[k].dst, vecs[k].cnt, vecs[k].stall,
                     vecs[k].lat, 1'b0, vecs[k].inj, vecs[k].exp_cyc,
                     vecs[k].fixed);

        // reset while waiting for read data
        stall_cfg = 0;
        lat_cfg = 3;
        rnd_cfg = 1'b0;
        use_fixed = 1'b0;
        @(negedge clk);
        src_address = 26'h0000040;
        dst_address = 26'h0000090;
        word_count = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("in read wait: busy", busy, 1);
        chk("in read wait: read", avm_read, 0);
        #2 n_rst = 1'b0;
        #1;
        chk_idle("async reset");
        chk("async reset writedata", avm_writedata, 0);
        @(negedge clk);
        n_rst = 1'b1;
        force_rdv = 1'b1;
        force_rdata = 32'h12345678;
        @(negedge clk);
        force_rdv = 1'b0;
        chk_idle("late valid");
        chk("late valid writedata", avm_writedata, 0);
        repeat (2) @(negedge clk);
        chk_idle("late valid later");

        for (int k = 0; k < 20; k++) begin
            logic [AW-1:0] s;
            logic [AW-1:0] d;
            s = AW'($urandom);
            d = AW'($urandom);
            if (k % 4 == 0) s = 26'h3FFFFFF - AW'($urandom_range(0, 3));
            run_xfer(s, d, CW'($urandom_range(0, 6)), 0, 1, 1'b1, 0, -1, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
